// File: rtl/case_7_sdiv_13s_7s_seq.sv
// Sequential signed divider, 13s / 7s, restoring, one quotient bit per enabled cycle.
// CASE_7_SDIV_REM_EN builds the remainder output; otherwise rem is tied to zero.
module case_7_sdiv_13s_7s_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 13,
   parameter int din1_WIDTH = 7,
   parameter int dout_WIDTH = 13
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  dz
);

   localparam int CW = $clog2(din0_WIDTH + 1);
   localparam logic [CW-1:0]         LAST  = CW'(din0_WIDTH - 1);
   localparam logic [CW-1:0]         ONE_C = CW'(1);
   localparam logic [din0_WIDTH-1:0] ONE_A = din0_WIDTH'(1);

   if (ID < 0 || dout_WIDTH != din0_WIDTH) begin : g_param_check
      $error("case_7_sdiv_13s_7s_seq: dout_WIDTH must equal din0_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                state, state_nx;
   logic [din0_WIDTH-1:0] quo;
   logic [din1_WIDTH-1:0] dvs;
   logic [din1_WIDTH:0]   part;
   logic [CW-1:0]         count;
   logic                  neg_q;
   logic                  zero_d;

   logic [din0_WIDTH-1:0] a_abs;
   logic [din1_WIDTH-1:0] b_abs;
   logic [din1_WIDTH+1:0] trial;
   logic                  ge;
   logic [din1_WIDTH:0]   part_nx;
   logic [din0_WIDTH-1:0] q_fix;

   assign a_abs = din0[din0_WIDTH-1] ? (~din0 + ONE_A) : din0;
   assign b_abs = din1[din1_WIDTH-1] ? (~din1 + din1_WIDTH'(1)) : din1;

   // Partial remainder never exceeds the divisor magnitude, so the trial fits comfortably.
   assign trial   = {part, quo[din0_WIDTH-1]};
   assign ge      = trial >= {2'b00, dvs};
   assign part_nx = ge ? (trial[din1_WIDTH:0] - {1'b0, dvs}) : trial[din1_WIDTH:0];
   assign q_fix   = neg_q ? (~quo + ONE_A) : quo;

   assign ready = (state == IDLE);
   assign done  = (state == DONE);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else if (ce) begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (count == LAST) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         quo    <= '0;
         dvs    <= '0;
         part   <= '0;
         count  <= '0;
         neg_q  <= 1'b0;
         zero_d <= 1'b0;
         dout   <= '0;
         dz     <= 1'b0;
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (start) begin
                  quo    <= a_abs;
                  dvs    <= b_abs;
                  part   <= '0;
                  count  <= '0;
                  neg_q  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                  zero_d <= (din1 == '0);
               end
            end
            CALC: begin
               part  <= part_nx;
               quo   <= {quo[din0_WIDTH-2:0], ge};
               count <= count + ONE_C;
            end
            FIX: begin
               dout <= zero_d ? '1 : dout_WIDTH'(q_fix);
               dz   <= zero_d;
            end
            default: ;
         endcase
      end
   end

`ifdef CASE_7_SDIV_REM_EN
   logic                  neg_r;
   logic [din1_WIDTH-1:0] r_fix;

   // Remainder follows the dividend's sign (C truncating division).
   assign r_fix = neg_r ? (~part[din1_WIDTH-1:0] + din1_WIDTH'(1)) : part[din1_WIDTH-1:0];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         neg_r <= 1'b0;
         rem   <= '0;
      end else if (ce) begin
         if (state == IDLE && start) neg_r <= din0[din0_WIDTH-1];
         if (state == FIX) rem <= zero_d ? '0 : r_fix;
      end
   end
`else
   assign rem = '0;
`endif

endmodule

// File: tb/tb_case_7_sdiv_13s_7s_seq.sv
// Self-checking bench for case_7_sdiv_13s_7s_seq: directed corners plus randomized sweep
// against a plain-arithmetic reference (C-style truncating division).
module tb_case_7_sdiv_13s_7s_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n, ce, start;
   logic [12:0] din0;
   logic [6:0]  din1;
   logic        ready, done, dz;
   logic [12:0] dout;
   logic [6:0]  rem;

   int total = 0;
   int bad   = 0;

   always #5 ap_clk = ~ap_clk;

   case_7_sdiv_13s_7s_seq #(.ID(1), .din0_WIDTH(13), .din1_WIDTH(7), .dout_WIDTH(13)) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .ce      (ce),
      .start   (start),
      .din0    (din0),
      .din1    (din1),
      .ready   (ready),
      .done    (done),
      .dout    (dout),
      .rem     (rem),
      .dz      (dz)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [12:0] a, input logic [6:0] b,
                                 output logic [12:0] q, output logic [6:0] r, output logic z);
      int ai, bi;
      ai = int'($signed(a));
      bi = int'($signed(b));
      if (bi == 0) begin
         q = 13'h1FFF;
         r = 7'd0;
         z = 1'b1;
      end else begin
         q = 13'(ai / bi);
         r = 7'(ai % bi);
         z = 1'b0;
      end
`ifndef CASE_7_SDIV_REM_EN
      r = 7'd0;
`endif
   endfunction

   // One full operation: optional ce stall window, optional start/operand noise while busy,
   // optional ce=0 hold of the done pulse.
   task automatic run_op(input string tag, input logic [12:0] a, input logic [6:0] b,
                         input int st_at, input int st_len, input bit tog, input int hold);
      logic [12:0] eq;
      logic [6:0]  er;
      logic        ez;
      int          cyc;
      bit          busy_ready;
      model(a, b, eq, er, ez);
      chk({tag, "_idle_ready"}, 32'(ready), 32'd1);
      din0  = a;
      din1  = b;
      start = 1'b1;
      ce    = 1'b1;
      @(posedge ap_clk); #1;
      start      = 1'b0;
      cyc        = 1;
      busy_ready = 1'b0;
      while (done !== 1'b1 && cyc < 60) begin
         if (ready !== 1'b0) busy_ready = 1'b1;
         ce = (cyc >= st_at && cyc < st_at + st_len) ? 1'b0 : 1'b1;
         if (tog) begin
            start = 1'($urandom_range(0, 1));
            din0  = 13'($urandom);
            din1  = 7'($urandom);
         end
         @(posedge ap_clk); #1;
         cyc++;
      end
      start = 1'b0;
      ce    = 1'b1;
      if (ready !== 1'b0) busy_ready = 1'b1;
      chk({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
      chk({tag, "_latency"}, 32'(cyc), 32'(15 + st_len));
      chk({tag, "_dout"}, 32'(dout), 32'(eq));
      chk({tag, "_rem"}, 32'(rem), 32'(er));
      chk({tag, "_dz"}, 32'(dz), 32'(ez));
      for (int h = 0; h < hold; h++) begin
         ce = 1'b0;
         @(posedge ap_clk); #1;
         chk({tag, "_done_held"}, 32'(done), 32'd1);
      end
      ce = 1'b1;
      @(posedge ap_clk); #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready), 32'd1);
      chk({tag, "_dout_hold"}, 32'(dout), 32'(eq));
      chk({tag, "_dz_hold"}, 32'(dz), 32'(ez));
   endtask

   initial begin
      logic [6:0]  specials [4];
      logic [12:0] ra;
      logic [6:0]  rb;
      bit          extra_done;
      specials[0] = 7'(-64);
      specials[1] = 7'(-1);
      specials[2] = 7'(1);
      specials[3] = 7'(63);

      ap_rst_n = 1'b0;
      ce       = 1'b1;
      start    = 1'b0;
      din0     = '0;
      din1     = '0;
      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_rem", 32'(rem), 32'd0);
      chk("rst_dz", 32'(dz), 32'd0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      // Basic case, checked against literal values as well as the model.
      run_op("p100_7", 13'd100, 7'd7, 0, 0, 1'b0, 0);
      chk("lit_q_14", 32'(dout), 32'd14);
`ifdef CASE_7_SDIV_REM_EN
      chk("lit_r_2", 32'(rem), 32'd2);
`else
      chk("lit_r_0", 32'(rem), 32'd0);
`endif

      run_op("n100_7", 13'(-100), 7'd7, 0, 0, 1'b0, 0);
      run_op("p100_n7", 13'd100, 7'(-7), 0, 0, 1'b0, 0);
      run_op("n100_n7", 13'(-100), 7'(-7), 0, 0, 1'b0, 0);
      run_op("p4095_n64", 13'd4095, 7'(-64), 0, 0, 1'b0, 0);
      run_op("p5_0", 13'd5, 7'd0, 0, 0, 1'b0, 0);
      run_op("ovf", 13'h1000, 7'(-1), 0, 0, 1'b0, 0);
      chk("lit_ovf", 32'(dout), 32'h1000);

      // Four-cycle ce stall mid-CALC, busy start toggling, and a done pulse held by ce.
      run_op("stall4", 13'(-1234), 7'd37, 5, 4, 1'b1, 0);
      run_op("donehold", 13'd777, 7'(-9), 0, 0, 1'b1, 2);

      // Asynchronous reset at cycle 6 of an operation (last result is nonzero).
      run_op("pre_rst", 13'h1000, 7'(-1), 0, 0, 1'b0, 0);
      din0  = 13'd100;
      din1  = 7'd7;
      start = 1'b1;
      @(posedge ap_clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge ap_clk); #1;
      end
      ap_rst_n = 1'b0;
      #1;
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_rem", 32'(rem), 32'd0);
      chk("midrst_dz", 32'(dz), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      @(posedge ap_clk); #1;
      ap_rst_n   = 1'b1;
      extra_done = 1'b0;
      repeat (20) begin
         @(posedge ap_clk); #1;
         if (done !== 1'b0) extra_done = 1'b1;
      end
      chk("midrst_no_done", 32'(extra_done), 32'd0);
      run_op("post_rst", 13'd100, 7'd7, 0, 0, 1'b0, 0);

      // Limit divisors with random dividends.
      for (int i = 0; i < 8; i++) begin
         ra = 13'($urandom);
         run_op("special", ra, specials[i % 4], 0, 0, 1'b0, 0);
      end

      // Randomized sweep with occasional stalls and busy-time noise.
      for (int i = 0; i < 40; i++) begin
         ra = 13'($urandom);
         if ($urandom_range(0, 3) == 0) rb = specials[$urandom_range(0, 3)];
         else rb = 7'($urandom);
         run_op("rnd", ra, rb, int'($urandom_range(2, 10)), int'($urandom_range(0, 3)),
                1'(i % 3 == 0), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
